// File: rtl/bus_pkg.sv
`default_nettype none
// bus_pkg: AHB-lite transfer/response encodings and the bridge FSM state type.
// Rev 1.0
package bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Largest hsize the 32-bit APB side can carry (word).
  localparam logic [2:0] HSIZE_MAX = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_psel_decode.sv
`default_nettype none
// apb_psel_decode: slave index -> one-hot APB select, plus out-of-range flag.
// Rev 1.0
module apb_psel_decode #(
  parameter int NSLV  = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [NSLV-1:0]  psel_o,
  output logic             oob_o
);

  // One extra bit so NSLV == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] NSLV_C = (IDX_W+1)'(NSLV);

  assign oob_o = ({1'b0, idx_i} >= NSLV_C);

  for (genvar i = 0; i < NSLV; i++) begin : g_sel
    localparam logic [IDX_W-1:0] SEL_IDX = IDX_W'(i);
    assign psel_o[i] = (idx_i == SEL_IDX);
  end

endmodule
`default_nettype wire

// File: rtl/ahb_to_apb_bridge.sv
`default_nettype none
// ahb_to_apb_bridge: AHB-lite slave to APB master, fixed SETUP/ACCESS per transfer.
// Rev 1.0
module ahb_to_apb_bridge
  import bus_pkg::*;
#(
  parameter int NSLV      = 4,
  parameter int IDX_W     = 2,
  parameter int SLV_SHIFT = 12,
  parameter int APB_AW    = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [31:0]        hwdata,
  input  logic               hready_in,
  output logic               hreadyout,
  output logic               hresp,
  output logic [31:0]        hrdata,
  output logic [NSLV-1:0]    apb_psel,
  output logic               apb_penable,
  output logic               apb_pwrite,
  output logic [APB_AW-1:0]  apb_paddr,
  output logic [31:0]        apb_pwdata,
  input  logic [NSLV*32-1:0] apb_prdata
);

  bridge_state_e     state_q, state_d;
  logic [NSLV-1:0]   psel_q, psel_d, dec_psel;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              dec_oob, addr_valid, size_err;
  logic              haddr_unused;

  apb_psel_decode #(.NSLV(NSLV), .IDX_W(IDX_W)) u_dec (
    .idx_i  (haddr[SLV_SHIFT +: IDX_W]),
    .psel_o (dec_psel),
    .oob_o  (dec_oob)
  );

  assign addr_valid   = hsel & hready_in & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign size_err     = (hsize > HSIZE_MAX);
  assign haddr_unused = ^haddr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      psel_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    apb_penable = 1'b0;
    apb_pwdata  = pwdata_q;
    case (state_q)
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        pwdata_d   = hwdata;
        hreadyout  = 1'b0;
        apb_pwdata = hwdata;
      end
      ST_ERR1: begin
        state_d   = ST_ERR2;
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      default: begin
        // IDLE, ACCESS and ERR2 all accept a new address phase.
        if (state_q == ST_ACCESS) apb_penable = 1'b1;
        if (state_q == ST_ERR2)   hresp       = HRESP_ERROR;
        if (addr_valid) begin
          if (dec_oob | size_err) begin
            state_d = ST_ERR1;
            psel_d  = '0;
          end else begin
            state_d  = ST_SETUP;
            psel_d   = dec_psel;
            paddr_d  = haddr[APB_AW-1:0];
            pwrite_d = hwrite;
          end
        end else begin
          state_d = ST_IDLE;
          psel_d  = '0;
        end
      end
    endcase
  end

  always_comb begin
    hrdata = '0;
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < NSLV; i++) begin
        if (psel_q[i]) hrdata = hrdata | apb_prdata[32*i +: 32];
      end
    end
  end

  assign apb_psel   = psel_q;
  assign apb_paddr  = paddr_q;
  assign apb_pwrite = pwrite_q;

endmodule
`default_nettype wire
